// File: rtl/ipg_tx_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ipg_tx_sched_pkg : shared constants and encodings for the IPG TX path |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ipg_tx_sched_pkg;

  localparam int IPG_DATA_WIDTH = 64;
  localparam int IPG_LEN_WIDTH  = 6;
  localparam int IPG_MAX_BYTES  = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } ipg_state_t;

  // Request opcodes carried inside messages; shared with the RX debug processor.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } ipg_req_op_t;

endpackage
`default_nettype wire

// File: rtl/ipg_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ipg_rr_arbiter : combinational round-robin pick starting at rr_ptr    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ipg_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  int w_best;
  int w_sel;
  int w_dist;

  // Distance from the pointer (with wrap) ranks each request; smallest wins.
  always_comb begin
    w_best = NUM_REQ;
    w_sel  = 0;
    w_dist = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - int'(i_rr_ptr)) % NUM_REQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_sel  = i;
      end
    end
    o_idx   = IDX_W'(w_sel);
    o_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = (w_best < NUM_REQ) && (w_sel == i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ipg_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ipg_tx_sched : fills the TX inter-packet gap with message bytes from  |
// | NUM_REQ sources, locking a source for the length of its message.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ipg_tx_sched
  import ipg_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH = IPG_DATA_WIDTH,
  parameter int NUM_REQ    = 2,
  parameter int LEN_WIDTH  = IPG_LEN_WIDTH,
  parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [LEN_WIDTH-1:0]          tx_ipg_avail,
  output logic [DATA_WIDTH-1:0]         tx_ipg_data,
  output logic [LEN_WIDTH-1:0]          tx_ipg_len,
  output logic                          busy,
  output logic [IDX_W-1:0]              grant_id
);

  localparam int                 C_NB     = DATA_WIDTH / 8;
  localparam int                 C_REM_W  = $clog2(C_NB + 1);
  localparam logic [C_REM_W-1:0] C_MAX_B  = C_REM_W'(IPG_MAX_BYTES);
  localparam logic [C_REM_W-1:0] C_FULL_B = C_REM_W'(C_NB);

  ipg_state_t              r_state;
  logic [DATA_WIDTH-1:0]   r_buf;
  logic [C_REM_W-1:0]      r_rem;
  logic                    r_last;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [IDX_W-1:0]        r_grant;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic [LEN_WIDTH-1:0]    r_tx_len;

  logic [NUM_REQ-1:0]      w_arb_req;
  logic [NUM_REQ-1:0]      w_arb_grant;
  logic [IDX_W-1:0]        w_arb_idx;
  logic [NUM_REQ-1:0]      w_lock_hot;
  logic [IDX_W-1:0]        w_acc_idx;
  logic                    w_acc;
  logic [DATA_WIDTH-1:0]   w_word;
  logic                    w_word_last;
  logic [LEN_WIDTH-1:0]    w_avail_raw;
  logic [C_REM_W-1:0]      w_avail_b;
  logic [C_REM_W-1:0]      w_n;
  logic [C_REM_W-1:0]      w_rem_next;
  logic [C_REM_W+2:0]      w_shamt;
  logic [DATA_WIDTH-1:0]   w_mask;
  logic [DATA_WIDTH-1:0]   w_chunk;
  logic [LEN_WIDTH-1:0]    w_len;
  logic [IDX_W-1:0]        w_ptr_next;

  assign w_arb_req = (r_state == S_IDLE) ? req_valid : '0;

  ipg_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req    (w_arb_req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_arb_grant),
    .o_idx    (w_arb_idx)
  );

  always_comb begin
    w_lock_hot  = '0;
    w_word      = '0;
    w_word_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_lock_hot[i] = (IDX_W'(i) == r_grant);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == w_acc_idx) begin
        w_word      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_word_last = req_last[i];
      end
    end
  end

  assign req_ready = (r_state == S_IDLE) ? w_arb_grant :
                     (r_state == S_WAIT) ? w_lock_hot  : '0;
  assign w_acc_idx = (r_state == S_IDLE) ? w_arb_idx : r_grant;
  assign w_acc     = |(req_valid & req_ready);

  // Whole bytes only, and never more than seven per gap.
  assign w_avail_raw = tx_ipg_avail >> 3;
  assign w_avail_b   = (w_avail_raw > LEN_WIDTH'(IPG_MAX_BYTES)) ? C_MAX_B
                                                                 : w_avail_raw[C_REM_W-1:0];
  assign w_n         = (w_avail_b < r_rem) ? w_avail_b : r_rem;
  assign w_rem_next  = r_rem - w_n;
  assign w_shamt     = {w_n, 3'b000};
  assign w_mask      = ~({DATA_WIDTH{1'b1}} >> w_shamt);
  assign w_chunk     = r_buf & w_mask;
  assign w_len       = LEN_WIDTH'({w_n, 3'b000});
  assign w_ptr_next  = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_buf     <= '0;
      r_rem     <= '0;
      r_last    <= 1'b0;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_tx_data <= '0;
      r_tx_len  <= '0;
    end else begin
      r_tx_data <= '0;
      r_tx_len  <= '0;
      case (r_state)
        S_IDLE, S_WAIT: begin
          if (w_acc) begin
            r_buf   <= w_word;
            r_rem   <= C_FULL_B;
            r_last  <= w_word_last;
            r_grant <= w_acc_idx;
            r_busy  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          r_tx_data <= w_chunk;
          r_tx_len  <= w_len;
          r_buf     <= r_buf << w_shamt;
          r_rem     <= w_rem_next;
          if (w_rem_next == '0) begin
            if (r_last) begin
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
              r_rr_ptr <= w_ptr_next;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_ipg_data = r_tx_data;
  assign tx_ipg_len  = r_tx_len;
  assign busy        = r_busy;
  assign grant_id    = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_ipg_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ipg_tx_sched : byte-queue reference model with output scoreboard   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ipg_tx_sched;
  import ipg_tx_sched_pkg::*;

  localparam int DW = 64;
  localparam int NR = 2;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [LW-1:0] tx_ipg_avail;
  logic [DW-1:0] tx_ipg_data;
  logic [LW-1:0] tx_ipg_len;
  logic          busy;
  logic          grant_id;

  ipg_tx_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .tx_ipg_avail (tx_ipg_avail),
    .tx_ipg_data  (tx_ipg_data),
    .tx_ipg_len   (tx_ipg_len),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] d; logic l; } word_t;
  typedef struct packed { logic [LW-1:0] len; logic [DW-1:0] d; } out_t;

  int total = 0;
  int bad = 0;

  word_t src_q[NR][$];
  out_t  exp_q[$];
  logic [NR-1:0] hs = '0;
  bit    rand_avail = 0;
  bit    rand_hold = 0;
  int    fixed_avail = 0;

  byte unsigned m_bytes[$];
  int  m_owner = -1;
  int  m_ptr = 0;
  int  m_gid = 0;
  bit  m_last = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one byte queue for the word in flight, an owner for the lock.
  always @(negedge clk) begin
    logic [NR-1:0] er;
    out_t o;
    int nb;
    if (!rst_n) begin
      m_bytes.delete();
      m_owner = -1; m_ptr = 0; m_gid = 0; m_last = 0; hs = '0;
    end else begin
      er = '0;
      if (m_bytes.size() == 0) begin
        if (m_owner >= 0) er[m_owner] = 1'b1;
        else begin
          for (int k = 0; k < NR; k++) begin
            if (er == '0 && req_valid[(m_ptr + k) % NR]) er[(m_ptr + k) % NR] = 1'b1;
          end
        end
      end
      chk("ready", req_ready, er);
      chk("ready_onehot0", $onehot0(req_ready), 1);
      chk("busy", busy, m_owner >= 0);
      chk("grant_id", grant_id, m_gid);
      hs = req_valid & req_ready;
      o = '0;
      if (m_bytes.size() > 0) begin
        nb = tx_ipg_avail / 8;
        if (nb > 7) nb = 7;
        if (nb > m_bytes.size()) nb = m_bytes.size();
        for (int b = 0; b < nb; b++) o.d[DW-1-8*b -: 8] = m_bytes.pop_front();
        o.len = LW'(8 * nb);
        if (m_bytes.size() == 0 && m_last) begin
          m_ptr = (m_owner + 1) % NR;
          m_owner = -1;
        end
      end else begin
        for (int j = 0; j < NR; j++) begin
          if (er[j] && req_valid[j]) begin
            for (int b = 0; b < 8; b++) m_bytes.push_back(req_data[j*DW + DW-1-8*b -: 8]);
            m_last = req_last[j]; m_owner = j; m_gid = j;
          end
        end
      end
      exp_q.push_back(o);
    end
  end

  always @(posedge clk) begin
    out_t e;
    #2;
    if (!rst_n) begin
      exp_q.delete();
      chk("reset_len", tx_ipg_len, 0);
      chk("reset_data", tx_ipg_data, 0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("len", tx_ipg_len, e.len);
      chk("data", tx_ipg_data, e.d);
    end
  end

  // Source driver: holds valid until handshake, optionally inserts idle gaps.
  always @(posedge clk) begin
    #1;
    tx_ipg_avail = rand_avail ? LW'($urandom_range(0, 63)) : LW'(fixed_avail);
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) src_q[i].delete();
      req_valid = '0; req_data = '0; req_last = '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) void'(src_q[i].pop_front());
        if (req_valid[i] && !hs[i]) begin
        end else if (src_q[i].size() > 0 && (!rand_hold || $urandom_range(0, 3) != 0)) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0].d;
          req_last[i] = src_q[i][0].l;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic push(input int r, input logic [DW-1:0] d, input logic l);
    word_t w;
    w.d = d; w.l = l;
    src_q[r].push_back(w);
  endtask

  // mode 0: fully idle; 1: req0 locked and waiting; 2: four bytes left in buffer
  task automatic wait_for(input int mode, input int budget);
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk); #1;
      case (mode)
        0: done = (m_owner < 0) && (m_bytes.size() == 0) && (src_q[0].size() == 0) &&
                  (src_q[1].size() == 0) && (req_valid == '0);
        1: done = (m_owner == 0) && (m_bytes.size() == 0) && (src_q[0].size() == 0);
        default: done = (m_bytes.size() == 4);
      endcase
      n++;
      if (!done && n > budget) begin
        total++; bad++;
        $display("FAIL timeout mode %0d: waited %0d cycles, required condition", mode, n);
        return;
      end
    end
  endtask

  initial begin
    tx_ipg_avail = '0; req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_len", tx_ipg_len, 0);
    chk("rst_data", tx_ipg_data, 0);
    rst_n = 1'b1;

    fixed_avail = 56;
    push(0, 64'h1122334455667788, 1'b1);
    wait_for(0, 50);
    fixed_avail = 24;
    push(0, 64'h1122334455667788, 1'b1);
    wait_for(0, 50);

    fixed_avail = 56;
    for (int p = 0; p < 2; p++) begin
      push(0, {$urandom, $urandom}, 1'b1);
      push(1, {$urandom, $urandom}, 1'b1);
      wait_for(0, 100);
    end

    fixed_avail = 40;
    push(0, 64'h0102030405060708, 1'b0);
    push(1, 64'hF1F2F3F4F5F6F7F8, 1'b1);
    wait_for(1, 50);
    repeat (3) @(posedge clk);
    push(0, 64'h090A0B0C0D0E0F10, 1'b1);
    wait_for(0, 100);

    fixed_avail = 0;
    push(0, 64'hAABBCCDDEEFF0011, 1'b1);
    repeat (5) @(posedge clk);
    #2 fixed_avail = 13;
    @(posedge clk);
    #2 fixed_avail = 63;
    wait_for(0, 50);

    fixed_avail = 32;
    push(0, 64'hCAFEBABE12345678, 1'b1);
    wait_for(2, 50);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_len", tx_ipg_len, 0);
    chk("mid_rst_data", tx_ipg_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push(1, 64'h5566778899AABBCC, 1'b1);
    wait_for(0, 50);

    rand_avail = 1; rand_hold = 1;
    for (int m = 0; m < 60; m++) begin
      int r;
      int nw;
      r = int'($urandom_range(0, NR - 1));
      nw = int'($urandom_range(1, 3));
      for (int w = 0; w < nw; w++) push(r, {$urandom, $urandom}, w == nw - 1);
    end
    wait_for(0, 5000);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ipg_tx_sched.md
Name: ipg_tx_sched

Overview:
Shares the TX inter-packet-gap (IPG) side channel between NUM_REQ message sources, such as the read/write request generator and the ipg_reply_chunk responder. Each cycle the PHY reports how many gap bits it can carry. The block fills that space with bytes from the granted source's buffered word. Output is MSB-aligned data plus a bit length, the same format the RX-side IPG processor consumes (rx_ipg_data/rx_len). Multi-word messages are locked to one source until their last word is fully drained.

Parameters:
DATA_WIDTH, 64, chunk/word width in bits (byte multiple)
NUM_REQ, 2, number of requesters
LEN_WIDTH, 6, width of gap-length fields in bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_data  in  NUM_REQ*DATA_WIDTH  word per requester, slice i = bits [i*64 +: 64], MSB = first byte sent
req_last  in  NUM_REQ  word is final word of its message
req_valid  in  NUM_REQ  word available
req_ready  out  NUM_REQ  word accepted this cycle when valid&ready
tx_ipg_avail  in  LEN_WIDTH  gap bits the PHY can carry next cycle
tx_ipg_data  out  DATA_WIDTH  gap payload, MSB-aligned, unused low bits zero
tx_ipg_len  out  LEN_WIDTH  valid bits in tx_ipg_data (multiple of 8, 0..56)
busy  out  1  a message is locked
grant_id  out  $clog2(NUM_REQ)  requester currently locked

Behaviour:
- Reset (async, rst_n=0): state IDLE, buffer 0, rem_bytes 0, last_flag 0, rr_ptr 0, tx_ipg_data 0, tx_ipg_len 0, busy 0, grant_id 0, req_ready 0. A reset mid-message discards the buffered word with no partial output.
- States:
  - IDLE: no lock.
  - WAIT: locked, buffer empty, waiting for the next word of the message.
  - SEND: buffer holds rem_bytes (1..8) bytes.
- req_ready is combinational and one-hot or zero. It is asserted only in IDLE or WAIT.
  - IDLE: ready goes to the round-robin winner among req_valid, searching from rr_ptr upward with wrap.
  - WAIT: ready goes only to grant_id. Other requesters are never granted while locked.
- Accept (valid&ready):
  - buffer <= req_data slice, rem_bytes <= 8, last_flag <= req_last.
  - grant_id <= winner, busy <= 1, go to SEND.
  - No emission happens in the accept cycle, so there is a one-cycle bubble per word.
- SEND, each cycle:
  - avail_b = floor(tx_ipg_avail/8), capped at 7 bytes.
  - n = min(avail_b, rem_bytes).
  - Registered output: tx_ipg_len <= 8n, tx_ipg_data <= top 8n bits of buffer, rest zero.
  - buffer <= buffer << 8n, rem_bytes -= n.
  - If rem_bytes reaches 0: if last_flag, go to IDLE with busy<=0 and rr_ptr <= grant_id+1 (mod NUM_REQ); otherwise go to WAIT.
- Every cycle not emitting (IDLE, WAIT, SEND with n=0) registers tx_ipg_len<=0, tx_ipg_data<=0.
- Latency: tx_ipg_avail sampled in cycle t appears on the outputs in t+1.
- Boundaries:
  - avail=0 stalls the buffer.
  - Non-byte-multiple avail is floored (13 -> 8).
  - avail 56..63 yields at most 7 bytes.
  - A requester dropping valid during WAIT keeps the lock and outputs zero indefinitely (no timeout).
  - req_valid may not be withdrawn once its ready is seen; behaviour is undefined otherwise.
- Arithmetic: rem_bytes is 4 bits; the shift amount is 8n (≤56) on a 64-bit buffer.

Decomposition:
- Shared include ipg_defs.vh holds:
  - IPG_DATA_WIDTH=64, IPG_LEN_WIDTH=6, IPG_MAX_BYTES=7
  - state encodings S_IDLE/S_WAIT/S_SEND
  - request opcode constants (0 = read, 1 = write), also used by debug_ipg_proc
- One sub-module: ipg_rr_arbiter (NUM_REQ, req vector, rr_ptr in, one-hot grant and index out, combinational).

Test Plan:
- Single word, avail=56: req0 data 64'h1122334455667788, last=1. Outputs:
  - len 56, data 64'h1122334455667700
  - then len 8, data 64'h8800000000000000
  - then IDLE, busy=0
- Same word, avail=24: chunks 24/24/16 with data 64'h1122330000000000, 64'h4455660000000000, 64'h7788000000000000.
- Simultaneous req0/req1 single-word messages from reset: req0 served first, then req1. A repeated simultaneous pair serves req1 first? No: after req1, rr_ptr=0, so req0 is served first again. Check ready one-hot each cycle.
- Lock: req0 two-word message (last on word 2) with req1 valid throughout. req1 gets no ready until req0 word 2 is drained; this includes a WAIT gap where req0 valid is low for 3 cycles (len 0 outputs).
- Avail sweep 0, 13, 63 on 64'hAABBCCDDEEFF0011: lengths 0, 8, 56, then remaining 0 bytes cleared correctly.
- Assert rst_n low mid-SEND (rem_bytes=4): outputs 0 immediately. After release, a new req1 word is served from IDLE with rr_ptr=0.
